// File: rtl/cla_pkg.sv
// Shared constants and types for the serial carry-look-ahead adder.
package cla_pkg;

  // Bits handled by the look-ahead slice on each clock
  localparam int NIBBLE_W = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble counter width; at least one bit so that small operand sizes still get a counter
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 2) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_slice_4.sv
// Purely combinational 4-bit carry-look-ahead adder slice.
// Every carry is a flat sum of products of generate/propagate terms and ci, so there is no ripple path.
module cla_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  // Per-bit generate and propagate terms
  assign g = a & b;
  assign p = a ^ b;

  // Look-ahead carries, each expanded directly in terms of g, p and ci
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  // Sum bits are the propagate terms combined with the carry into each bit
  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_serial_adder.sv
// Wide adder that streams operands one nibble per clock through a single 4-bit CLA slice.
// Operands are accepted with a valid/ready handshake, and the result is held under valid/ready until it is consumed.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   A,
  input  logic [NIBBLE_W*NIBBLES-1:0]   B,
  input  logic                          Cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   Sum,
  output logic                          Cout,
  output logic                          Ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  logic [1:0]          state_q;
  logic [CW-1:0]       cnt_q;
  logic                carry_q;
  logic [W-1:0]        a_sh;
  logic [W-1:0]        b_sh;
  logic [W-NIBBLE_W-1:0] sum_sh;
  logic                a_msb_q;
  logic                b_msb_q;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;
  logic [W-1:0]        assembled;

  // The one look-ahead slice, always fed from the low end of the operand shift registers
  cla_slice_4 u_slice (
    .a  (a_sh[NIBBLE_W-1:0]),
    .b  (b_sh[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // The new nibble enters at the top, so after the last nibble the word is in natural order
  assign assembled = {slice_s, sum_sh};

  // Handshake outputs are decoded from state and masked while reset is held
  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = (state_q == ST_DONE) & ~rst;

  // Sequencer: latch operands, step one nibble per clock, publish the result, and wait for the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh    <= A;
            b_sh    <= B;
            carry_q <= Cin;
            a_msb_q <= A[W-1];
            b_msb_q <= B[W-1];
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh    <= {{NIBBLE_W{1'b0}}, a_sh[W-1:NIBBLE_W]};
          b_sh    <= {{NIBBLE_W{1'b0}}, b_sh[W-1:NIBBLE_W]};
          carry_q <= slice_co;
          sum_sh  <= assembled[W-1:NIBBLE_W];
          if (cnt_q == LAST_NIB) begin
            Sum     <= assembled;
            Cout    <= slice_co;
            Ovf     <= (a_msb_q == b_msb_q) && (slice_s[NIBBLE_W-1] != a_msb_q);
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for the serial CLA adder: the driver pushes model results, and the monitor pops them on each output handshake.
module tb_cla_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Cin;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  Sum;
  logic          Cout;
  logic          Ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests      = 0;
  int   fails      = 0;
  int   cyc        = 0;
  int   ready_mode = 1;
  logic prev_valid = 1'b0;

  cla_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to measure acceptance-to-valid latency
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: out_ready held low, held high, or randomised, depending on the selected mode
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic for the unsigned result and the signed range
  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int acc);
    exp_t e;
    int   total;
    int   stotal;
    total  = int'(a) + int'(b) + int'(cin);
    stotal = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.sum  = total[W-1:0];
    e.cout = (total > 65535);
    e.ovf  = (stotal > 32767) || (stotal < -32768);
    e.acc  = acc;
    return e;
  endfunction

  // Offer one operand set, wait for acceptance, then scramble the inputs so that later changes can be seen to have no effect
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'(1));
      return;
    end
    A        = a;
    B        = b;
    Cin      = cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(refModel(a, b, cin, cyc));
    in_valid = 1'b0;
    A        = W'($urandom);
    B        = W'($urandom);
    Cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int waitc = 0;
    while (exp_q.size() != 0 && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'(0));
  endtask

  // Monitor: check latency on each rising out_valid and check the result on each completed handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0)
          checkOutput("spurious_valid", 32'(out_valid), 32'(0));
        else
          checkOutput("latency", 32'(cyc - exp_q[0].acc), 32'(NIBBLES));
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("sum",  32'(Sum),  32'(mon_e.sum));
        checkOutput("cout", 32'(Cout), 32'(mon_e.cout));
        checkOutput("ovf",  32'(Ovf),  32'(mon_e.ovf));
      end
    end
    prev_valid = out_valid;
  end

  // Watchdog so that the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitc;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    Cin      = 1'b0;

    // Reset state while reset is still asserted
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(in_ready),  32'(0));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_sum",       32'(Sum),       32'(0));
    checkOutput("rst_cout",      32'(Cout),      32'(0));
    checkOutput("rst_ovf",       32'(Ovf),       32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'(1));

    // Directed corner cases: zero, full carry chain, signed overflow, and carry-in
    ready_mode = 1;
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    applyStimulus(16'hABCD, 16'h1234, 1'b1);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Back-pressure: result held with out_ready low while new operands are waved at the input
    ready_mode = 0;
    @(posedge clk);
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    waitc = 0;
    while (!out_valid && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A        = W'($urandom);
      B        = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'(1));
      checkOutput("bp_in_ready",  32'(in_ready),  32'(0));
      checkOutput("bp_sum",       32'(Sum),       32'(16'h5555));
      checkOutput("bp_cout",      32'(Cout),      32'(0));
      checkOutput("bp_ovf",       32'(Ovf),       32'(0));
    end
    in_valid   = 1'b0;
    ready_mode = 1;
    waitc = 0;
    while (out_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'(1));
    drain();

    // Reset asserted during the second RUN cycle discards the operation
    applyStimulus(16'h0F0F, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 32'(out_valid), 32'(0));
      if (i == 0) checkOutput("abort_in_ready", 32'(in_ready), 32'(1));
    end
    applyStimulus(16'h0001, 16'h0002, 1'b0);
    drain();

    // Randomised traffic with a randomised consumer
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
